// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: op codes, FSM states, size helpers.
// Optional build macro: MEM_MISALIGN_CHECK_EN.
package mem_stage_pkg;

   localparam int REG_BUS    = 64;
   localparam int MEM_OP_BUS = 4;

   typedef enum logic [MEM_OP_BUS-1:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LH   = 4'd2,
      MEM_LW   = 4'd3,
      MEM_LD   = 4'd4,
      MEM_LBU  = 4'd5,
      MEM_LHU  = 4'd6,
      MEM_LWU  = 4'd7,
      MEM_SB   = 4'd8,
      MEM_SH   = 4'd9,
      MEM_SW   = 4'd10,
      MEM_SD   = 4'd11
   } mem_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } mem_state_e;

   // log2 of the access size in bytes
   function automatic logic [1:0] op_size(input mem_op_e op);
      case (op)
         MEM_LB, MEM_LBU, MEM_SB: op_size = 2'd0;
         MEM_LH, MEM_LHU, MEM_SH: op_size = 2'd1;
         MEM_LW, MEM_LWU, MEM_SW: op_size = 2'd2;
         default:                 op_size = 2'd3;
      endcase
   endfunction

   function automatic logic is_store(input mem_op_e op);
      is_store = (op == MEM_SB) || (op == MEM_SH) ||
                 (op == MEM_SW) || (op == MEM_SD);
   endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data lane shift and sign/zero extension.
// Purely combinational; used once inside mem_stage.
module load_ext
   import mem_stage_pkg::*;
(
   input  logic [REG_BUS-1:0]    rdata,
   input  logic [MEM_OP_BUS-1:0] op,
   input  logic [2:0]            off,
   output logic [REG_BUS-1:0]    data
);

   mem_op_e            op_e;
   logic [REG_BUS-1:0] shifted;

   assign op_e    = mem_op_e'(op);
   assign shifted = rdata >> {off, 3'b000};

   always_comb begin
      data = shifted;
      case (op_e)
         MEM_LB:  data = {{56{shifted[7]}}, shifted[7:0]};
         MEM_LH:  data = {{48{shifted[15]}}, shifted[15:0]};
         MEM_LW:  data = {{32{shifted[31]}}, shifted[31:0]};
         MEM_LBU: data = {56'd0, shifted[7:0]};
         MEM_LHU: data = {48'd0, shifted[15:0]};
         MEM_LWU: data = {32'd0, shifted[31:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data bus master with pipeline stall.
// MEM_MISALIGN_CHECK_EN turns misaligned accesses into a misalign pulse.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  me_valid,
   input  logic [MEM_OP_BUS-1:0] me_mem_op,
   input  logic [REG_BUS-1:0]    me_alu_result,
   input  logic [REG_BUS-1:0]    me_rs2_data,
   output logic [REG_BUS-1:0]    mem_rd_data,
   output logic                  mem_stall,
   output logic                  mem_misalign,
   output logic                  dbus_req,
   output logic                  dbus_we,
   output logic [REG_BUS-1:0]    dbus_addr,
   output logic [REG_BUS-1:0]    dbus_wdata,
   output logic [7:0]            dbus_wmask,
   input  logic [REG_BUS-1:0]    dbus_rdata,
   input  logic                  dbus_ack
);

   mem_state_e         state, state_nx;
   mem_op_e            op_in, op_q;
   logic [2:0]         off_q;
   logic [REG_BUS-1:0] ld_q, ld_ext;
   logic [REG_BUS-1:0] addr_al, wdata_in;
   logic [7:0]         wmask_in;
   logic [1:0]         sz;
   logic               is_mem, accept, mis;

   assign op_in  = mem_op_e'(me_mem_op);
   assign is_mem = (op_in != MEM_NONE);
   assign sz     = op_size(op_in);

   // drop address bits below the access size
   always_comb begin
      addr_al  = me_alu_result;
      wmask_in = 8'h01;
      case (sz)
         2'd0: wmask_in = 8'h01;
         2'd1: begin
            addr_al[0] = 1'b0;
            wmask_in   = 8'h03;
         end
         2'd2: begin
            addr_al[1:0] = 2'b00;
            wmask_in     = 8'h0F;
         end
         default: begin
            addr_al[2:0] = 3'b000;
            wmask_in     = 8'hFF;
         end
      endcase
      wmask_in = wmask_in << addr_al[2:0];
   end

   assign wdata_in = me_rs2_data << {addr_al[2:0], 3'b000};

`ifdef MEM_MISALIGN_CHECK_EN
   assign mis = (state == ST_IDLE) && me_valid && is_mem &&
                (addr_al[2:0] != me_alu_result[2:0]);
`else
   assign mis = 1'b0;
`endif

   assign accept = (state == ST_IDLE) && me_valid && is_mem && !mis;

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (accept) state_nx = ST_REQ;
         ST_REQ:  if (dbus_ack) state_nx = ST_DONE;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_wdata <= '0;
         dbus_wmask <= '0;
         op_q       <= MEM_NONE;
         off_q      <= '0;
         ld_q       <= '0;
      end else begin
         state    <= state_nx;
         dbus_req <= (state_nx == ST_REQ);
         if (accept) begin
            dbus_we    <= is_store(op_in);
            dbus_addr  <= {addr_al[REG_BUS-1:3], 3'b000};
            dbus_wdata <= wdata_in;
            dbus_wmask <= wmask_in;
            op_q       <= op_in;
            off_q      <= addr_al[2:0];
         end
         if (state == ST_REQ && dbus_ack) ld_q <= ld_ext;
      end
   end

   load_ext u_load_ext (
      .rdata (dbus_rdata),
      .op    (op_q),
      .off   (off_q),
      .data  (ld_ext)
   );

   // reset forces the combinational outputs low as well
   always_comb begin
      mem_rd_data = me_alu_result;
      if (state == ST_DONE) mem_rd_data = is_store(op_q) ? '0 : ld_q;
      if (mis || rst) mem_rd_data = '0;
   end

   assign mem_stall    = !rst && (accept || state == ST_REQ);
   assign mem_misalign = !rst && mis;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage with a byte-level reference model.
// Honors MEM_MISALIGN_CHECK_EN the same way as the design build.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        me_valid;
   logic [3:0]  me_mem_op;
   logic [63:0] me_alu_result, me_rs2_data;
   logic [63:0] mem_rd_data;
   logic        mem_stall, mem_misalign;
   logic        dbus_req, dbus_we;
   logic [63:0] dbus_addr, dbus_wdata;
   logic [7:0]  dbus_wmask;
   logic [63:0] dbus_rdata;
   logic        dbus_ack;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [63:0] result;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic        we;
      logic        unstable;
      logic        misalign;
      logic        done;
      logic        req_end;
      logic [7:0]  stalls;
      logic [7:0]  reqs;
   } obs_t;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk           (clk),
      .rst           (rst),
      .me_valid      (me_valid),
      .me_mem_op     (me_mem_op),
      .me_alu_result (me_alu_result),
      .me_rs2_data   (me_rs2_data),
      .mem_rd_data   (mem_rd_data),
      .mem_stall     (mem_stall),
      .mem_misalign  (mem_misalign),
      .dbus_req      (dbus_req),
      .dbus_we       (dbus_we),
      .dbus_addr     (dbus_addr),
      .dbus_wdata    (dbus_wdata),
      .dbus_wmask    (dbus_wmask),
      .dbus_rdata    (dbus_rdata),
      .dbus_ack      (dbus_ack)
   );

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [3:0] op);
      case (op)
         4'd1, 4'd5, 4'd8:  return 1;
         4'd2, 4'd6, 4'd9:  return 2;
         4'd3, 4'd7, 4'd10: return 4;
         default:           return 8;
      endcase
   endfunction

   function automatic bit m_store(input logic [3:0] op);
      return op >= 4'd8 && op <= 4'd11;
   endfunction

   function automatic bit m_signed(input logic [3:0] op);
      return op == 4'd1 || op == 4'd2 || op == 4'd3;
   endfunction

   function automatic bit m_misal(input logic [3:0] op, input logic [63:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
      return op != 4'd0 && (a % nbytes(op)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic int m_off(input logic [3:0] op, input logic [63:0] a);
      int n = nbytes(op);
      return int'((a - (a % n)) % 8);
   endfunction

   function automatic logic [63:0] m_load(input logic [3:0] op,
                                          input logic [63:0] a,
                                          input logic [63:0] rd);
      int n = nbytes(op);
      int off = m_off(op, a);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
      if (m_signed(op) && v[8*n-1])
         for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic logic [7:0] m_mask(input logic [3:0] op,
                                         input logic [63:0] a);
      logic [7:0] m = '0;
      for (int i = 0; i < nbytes(op); i++) m[m_off(op, a) + i] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] m_wdata(input logic [3:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] d);
      logic [63:0] w = '0;
      int off = m_off(op, a);
      for (int i = 0; i + off < 8; i++) w[8*(off+i) +: 8] = d[8*i +: 8];
      return w;
   endfunction

   // ---------------- driver / bus responder ----------------
   // Called just after a rising edge; returns just after a rising edge.
   task automatic run_mem(input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] rs2, input logic [63:0] rd,
                          input int waits, output obs_t o);
      o = '0;
      me_valid      = 1'b1;
      me_mem_op     = op;
      me_alu_result = a;
      me_rs2_data   = rs2;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (dbus_req) begin
            if (o.reqs == 0) begin
               o.addr  = dbus_addr;
               o.wdata = dbus_wdata;
               o.wmask = dbus_wmask;
               o.we    = dbus_we;
            end else if (dbus_addr !== o.addr || dbus_wdata !== o.wdata ||
                         dbus_wmask !== o.wmask || dbus_we !== o.we) begin
               o.unstable = 1'b1;
            end
            o.reqs++;
            dbus_ack   = (int'(o.reqs) > waits);
            dbus_rdata = dbus_ack ? rd : {$urandom, $urandom};
         end else begin
            dbus_ack = 1'b0;
         end
         if (mem_misalign) o.misalign = 1'b1;
         if (mem_stall) o.stalls++;
         else begin
            o.result  = mem_rd_data;
            o.req_end = dbus_req;
            o.done    = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      me_valid  = 1'b0;
      me_mem_op = 4'd0;
      dbus_ack  = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      rst           = 1'b1;
      me_valid      = 1'b1;
      me_mem_op     = 4'd4;
      me_alu_result = 64'h1234;
      me_rs2_data   = 64'h5678;
      dbus_ack      = 1'b0;
      dbus_rdata    = '0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (dbus_req !== 1'b0 || mem_stall !== 1'b0 || mem_misalign !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctl: req=%b stall=%b mis=%b, want 0",
                  dbus_req, mem_stall, mem_misalign);
      end
      tests++;
      if (dbus_addr !== 64'd0 || dbus_wdata !== 64'd0 ||
          dbus_wmask !== 8'd0 || dbus_we !== 1'b0) begin
         fails++;
         $display("FAIL reset_bus: addr=%h wdata=%h mask=%h we=%b, want 0",
                  dbus_addr, dbus_wdata, dbus_wmask, dbus_we);
      end
      tests++;
      if (mem_rd_data !== 64'd0) begin
         fails++;
         $display("FAIL reset_rd: got %h want 0", mem_rd_data);
      end
      me_valid  = 1'b0;
      me_mem_op = 4'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_store_byte;
      obs_t o;
      run_mem(4'd8, 64'h1003, 64'hAB, 64'h0, 0, o);
      tests++;
      if (o.addr !== 64'h1000 || o.wmask !== 8'h08 ||
          o.wdata !== 64'hAB00_0000 || o.we !== 1'b1) begin
         fails++;
         $display("FAIL sb_bus: addr=%h mask=%h wdata=%h we=%b want 1000 08 ab000000 1",
                  o.addr, o.wmask, o.wdata, o.we);
      end
      tests++;
      if (o.stalls !== 8'd2 || o.reqs !== 8'd1) begin
         fails++;
         $display("FAIL sb_timing: stalls=%0d reqs=%0d want 2 1", o.stalls, o.reqs);
      end
      tests++;
      if (o.result !== 64'd0 || o.req_end !== 1'b0) begin
         fails++;
         $display("FAIL sb_done: rd=%h req=%b want 0 0", o.result, o.req_end);
      end
   endtask

   task automatic test_load_byte;
      obs_t o;
      logic [63:0] rd;
      rd = {8'h80, 24'($urandom), 32'($urandom)};
      run_mem(4'd1, 64'h2007, 64'h0, rd, 0, o);
      tests++;
      if (o.result !== 64'hFFFF_FFFF_FFFF_FF80) begin
         fails++;
         $display("FAIL lb_sext: got %h want ffffffffffffff80", o.result);
      end
      run_mem(4'd5, 64'h2007, 64'h0, rd, 1, o);
      tests++;
      if (o.result !== 64'h80 || o.we !== 1'b0) begin
         fails++;
         $display("FAIL lbu_zext: got %h we=%b want 80 0", o.result, o.we);
      end
   endtask

   task automatic test_lwu_wait;
      obs_t o;
      run_mem(4'd7, 64'h3004, 64'h0, 64'hDEAD_BEEF_0000_0000, 3, o);
      tests++;
      if (o.stalls !== 8'd5 || o.reqs !== 8'd4 || o.unstable !== 1'b0) begin
         fails++;
         $display("FAIL lwu_wait: stalls=%0d reqs=%0d unstable=%b want 5 4 0",
                  o.stalls, o.reqs, o.unstable);
      end
      tests++;
      if (o.result !== 64'h0000_0000_DEAD_BEEF || o.addr !== 64'h3000) begin
         fails++;
         $display("FAIL lwu_data: rd=%h addr=%h want deadbeef 3000", o.result, o.addr);
      end
   endtask

   task automatic test_passthrough;
      me_valid      = 1'b1;
      me_mem_op     = 4'd0;
      me_alu_result = 64'h42;
      #1;
      tests++;
      if (mem_rd_data !== 64'h42) begin
         fails++;
         $display("FAIL pass_rd: got %h want 42", mem_rd_data);
      end
      @(negedge clk);
      tests++;
      if (mem_stall !== 1'b0 || dbus_req !== 1'b0) begin
         fails++;
         $display("FAIL pass_ctl: stall=%b req=%b want 0 0", mem_stall, dbus_req);
      end
      me_valid      = 1'b0;
      me_mem_op     = 4'd4;
      me_alu_result = 64'h77;
      #1;
      tests++;
      if (mem_stall !== 1'b0 || mem_rd_data !== 64'h77) begin
         fails++;
         $display("FAIL invalid_ld: stall=%b rd=%h want 0 77", mem_stall, mem_rd_data);
      end
      @(posedge clk);
      #1;
      tests++;
      if (dbus_req !== 1'b0) begin
         fails++;
         $display("FAIL invalid_req: got %b want 0", dbus_req);
      end
      me_mem_op = 4'd0;
   endtask

   task automatic test_stray_ack;
      obs_t o;
      logic [63:0] rd;
      dbus_ack   = 1'b1;
      dbus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin
         fails++;
         $display("FAIL stray_ack: req=%b stall=%b want 0 0", dbus_req, mem_stall);
      end
      dbus_ack = 1'b0;
      rd = {$urandom, $urandom};
      run_mem(4'd4, 64'h4000, 64'h0, rd, 2, o);
      tests++;
      if (o.result !== rd || o.stalls !== 8'd4) begin
         fails++;
         $display("FAIL ld_after_stray: rd=%h stalls=%0d want %h 4", o.result, o.stalls, rd);
      end
   endtask

   task automatic test_reset_mid_req;
      obs_t o;
      logic [63:0] rd;
      me_valid      = 1'b1;
      me_mem_op     = 4'd4;
      me_alu_result = 64'h5008;
      dbus_ack      = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (dbus_req !== 1'b1) begin
         fails++;
         $display("FAIL mid_req_setup: req=%b want 1", dbus_req);
      end
      #2 rst = 1'b1;
      #1;
      tests++;
      if (dbus_req !== 1'b0 || mem_stall !== 1'b0) begin
         fails++;
         $display("FAIL mid_req_reset: req=%b stall=%b want 0 0", dbus_req, mem_stall);
      end
      me_valid  = 1'b0;
      me_mem_op = 4'd0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd = {$urandom, $urandom};
      run_mem(4'd4, 64'h5010, 64'h0, rd, 0, o);
      tests++;
      if (o.result !== rd || o.stalls !== 8'd2 || o.addr !== 64'h5010) begin
         fails++;
         $display("FAIL ld_after_reset: rd=%h stalls=%0d addr=%h want %h 2 5010",
                  o.result, o.stalls, o.addr, rd);
      end
   endtask

   task automatic test_misalign;
      obs_t o;
      logic [63:0] rd;
      rd = {$urandom, $urandom};
      run_mem(4'd3, 64'h1002, 64'h0, rd, 0, o);
`ifdef MEM_MISALIGN_CHECK_EN
      tests++;
      if (o.misalign !== 1'b1 || o.reqs !== 8'd0 || o.stalls !== 8'd0 ||
          o.result !== 64'd0) begin
         fails++;
         $display("FAIL lw_misalign: mis=%b reqs=%0d stalls=%0d rd=%h want 1 0 0 0",
                  o.misalign, o.reqs, o.stalls, o.result);
      end
`else
      tests++;
      if (o.addr !== 64'h1000 || o.wmask !== 8'h0F || o.reqs !== 8'd1 ||
          o.misalign !== 1'b0 || o.result !== m_load(4'd3, 64'h1002, rd)) begin
         fails++;
         $display("FAIL lw_forced_align: addr=%h mask=%h reqs=%0d mis=%b rd=%h want 1000 0f 1 0 %h",
                  o.addr, o.wmask, o.reqs, o.misalign, o.result,
                  m_load(4'd3, 64'h1002, rd));
      end
`endif
   endtask

   task automatic test_random;
      obs_t o;
      logic [3:0]  op;
      logic [63:0] a, rs2, rd, exp_rd;
      int          w, bad;
      for (int k = 0; k < 60; k++) begin
         op  = 4'($urandom_range(0, 11));
         a   = {$urandom, $urandom};
         rs2 = {$urandom, $urandom};
         rd  = {$urandom, $urandom};
         w   = $urandom_range(0, 3);
         run_mem(op, a, rs2, rd, w, o);
         bad = 0;
         if (!o.done) bad = 1;
         else if (op == 4'd0) begin
            if (o.result !== a || o.stalls !== 8'd0 || o.reqs !== 8'd0) bad = 2;
         end else if (m_misal(op, a)) begin
            if (o.result !== 64'd0 || o.misalign !== 1'b1 || o.reqs !== 8'd0) bad = 3;
         end else begin
            exp_rd = m_store(op) ? 64'd0 : m_load(op, a, rd);
            if (int'(o.stalls) != 2 + w || int'(o.reqs) != 1 + w) bad = 4;
            else if (o.addr !== {a[63:3], 3'b000} || o.we !== m_store(op) ||
                     o.wmask !== m_mask(op, a)) bad = 5;
            else if (m_store(op) && o.wdata !== m_wdata(op, a, rs2)) bad = 6;
            else if (o.result !== exp_rd || o.unstable || o.misalign) bad = 7;
         end
         tests++;
         if (bad != 0) begin
            fails++;
            $display("FAIL rand[%0d] kind=%0d op=%0d a=%h w=%0d: rd=%h addr=%h mask=%h wdata=%h stalls=%0d reqs=%0d; want rd=%h mask=%h wdata=%h",
                     k, bad, op, a, w, o.result, o.addr, o.wmask, o.wdata,
                     o.stalls, o.reqs,
                     m_store(op) ? 64'd0 : m_load(op, a, rd),
                     m_mask(op, a), m_wdata(op, a, rs2));
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_byte();
      test_lwu_wait();
      test_passthrough();
      test_stray_ack();
      test_reset_mid_req();
      test_misalign();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
